// File: rtl/mem_responder.sv
// Byte-addressed memory responder: one request per handshake, fixed wait, one-cycle completion pulse.
// Optional MEM_RESP_ERR_EN adds O_error for invalid size or odd-address word access.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | request latched, counting down to the access edge
// RESP  | completion pulse on O_data_ready
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_exec,
    input  logic        I_write,
    input  logic [1:0]  I_size,
    input  logic [15:0] I_addr,
    input  logic [15:0] I_data,
    output logic        O_ready,
    output logic [15:0] O_data,
    output logic        O_data_ready
`ifdef MEM_RESP_ERR_EN
    ,
    output logic        O_error
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic                  write_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           data_q;
    logic [7:0]            mem [DEPTH];

    logic                  access;
    logic                  size_byte;
    logic                  size_word;
    logic [ADDR_WIDTH-1:0] addr_hi;
    logic [15:0]           rdata;
    logic                  unused_addr;

    assign unused_addr = ^I_addr[15:ADDR_WIDTH];
    assign access      = (state == WAIT) && (count == '0);
    assign size_byte   = (size_q == 2'd1);
    assign size_word   = (size_q == 2'd2);
    // High byte of a word wraps naturally at the top of the array.
    assign addr_hi     = addr_q + ADDR_WIDTH'(1);

    always_comb begin
        rdata = 16'h0000;
        if (size_byte)
            rdata = {8'h00, mem[addr_q]};
        else if (size_word)
            rdata = {mem[addr_hi], mem[addr_q]};
    end

    // Storage is never reset; a reset on the access edge suppresses the write.
    always_ff @(posedge I_clk) begin
        if (access && !I_reset && write_q) begin
            if (size_byte || size_word)
                mem[addr_q] <= data_q[7:0];
            if (size_word)
                mem[addr_hi] <= data_q[15:8];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state        <= IDLE;
            count        <= '0;
            O_ready      <= 1'b1;
            O_data       <= 16'h0000;
            O_data_ready <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            data_q       <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (I_exec) begin
                        write_q <= I_write;
                        size_q  <= I_size;
                        addr_q  <= I_addr[ADDR_WIDTH-1:0];
                        data_q  <= I_data;
                        count   <= CW'(WAIT_CYCLES);
                        O_ready <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        if (!write_q)
                            O_data <= rdata;
                        O_data_ready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    O_data_ready <= 1'b0;
                    O_ready      <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    O_data_ready <= 1'b0;
                    O_ready      <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_RESP_ERR_EN
    always_ff @(posedge I_clk) begin
        if (I_reset)
            O_error <= 1'b0;
        else
            O_error <= access && (!(size_byte || size_word) || (size_word && addr_q[0]));
    end
`endif

endmodule
